// File: rtl/adder_ctl_pkg.sv
// Shared types and helpers for the indexed effective-address add sequencer.
package adder_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD_LO,
    ST_DRIVE_LO,
    ST_ADD_HI,
    ST_DRIVE_HI
  } state_e;

  localparam logic [1:0] MODE_ZPX  = 2'b00;
  localparam logic [1:0] MODE_ABSX = 2'b01;
  localparam logic [1:0] MODE_ABSY = 2'b10;
  localparam logic [1:0] MODE_ZPY  = 2'b11;

  function automatic logic is_abs(input logic [1:0] mode);
    return (mode == MODE_ABSX) || (mode == MODE_ABSY);
  endfunction

endpackage

// File: rtl/add_drive_timer.sv
// Load/decrement counter that flags the final cycle of a drive state.
module add_drive_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/indexed_add_sequencer.sv
// Control FSM sequencing the ALU and adder hold register through an indexed
// effective-address add: low byte, optional high-byte fixup, bus drive.
module indexed_add_sequencer #(
  parameter int unsigned DRIVE_CYCLES         = 1,
  parameter bit          FORCE_FIXUP_ON_WRITE = 1'b1
) (
  input  logic       phi_2,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       is_write,
  input  logic       abort,
  input  logic       alu_carry_out,
  output logic       busy,
  output logic       index_sel,
  output logic       alu_add,
  output logic       alu_sel_hi,
  output logic       alu_carry_in,
  output logic       add_adl,
  output logic       add_sb_60,
  output logic       add_sb_7,
  output logic       page_cross,
  output logic       done
);

  import adder_ctl_pkg::*;

  localparam logic [1:0] LOAD_VAL = 2'(DRIVE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       is_write_q, is_write_d;
  logic       index_sel_q, index_sel_d;
  logic       c_q, c_d;
  logic       page_cross_q, page_cross_d;

  logic timer_load;
  logic drive_last;
  logic need_fixup;
  logic done_now;
  logic accept;

  assign timer_load = (state_q == ST_ADD_LO) || (state_q == ST_ADD_HI);

  add_drive_timer #(.WIDTH(2)) u_timer (
    .clk      (phi_2),
    .reset    (reset),
    .load     (timer_load),
    .load_val (LOAD_VAL),
    .last     (drive_last)
  );

  // Zp modes discard the carry (8-bit wrap), so only abs modes may fix up.
  assign need_fixup = is_abs(mode_q) &&
                      (c_q || (is_write_q && FORCE_FIXUP_ON_WRITE));
  assign done_now   = drive_last &&
                      (((state_q == ST_DRIVE_LO) && !need_fixup) ||
                       (state_q == ST_DRIVE_HI));
  assign accept     = start && ((state_q == ST_IDLE) || done_now);

  always_ff @(posedge phi_2) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_ZPX;
      is_write_q   <= 1'b0;
      index_sel_q  <= 1'b0;
      c_q          <= 1'b0;
      page_cross_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      is_write_q   <= is_write_d;
      index_sel_q  <= index_sel_d;
      c_q          <= c_d;
      page_cross_q <= page_cross_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    is_write_d   = is_write_q;
    index_sel_d  = index_sel_q;
    c_d          = c_q;
    page_cross_d = page_cross_q;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADD_LO: begin
          c_d          = alu_carry_out;
          page_cross_d = alu_carry_out && is_abs(mode_q);
          state_d      = ST_DRIVE_LO;
        end
        ST_DRIVE_LO: if (drive_last) state_d = need_fixup ? ST_ADD_HI : ST_IDLE;
        ST_ADD_HI:   state_d = ST_DRIVE_HI;
        ST_DRIVE_HI: if (drive_last) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
      // A start in the done cycle chains straight into ADD_LO.
      if (accept) begin
        state_d      = ST_ADD_LO;
        mode_d       = mode;
        is_write_d   = is_write;
        index_sel_d  = mode[1];
        page_cross_d = 1'b0;
      end
    end
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    alu_add      = 1'b0;
    alu_sel_hi   = 1'b0;
    alu_carry_in = 1'b0;
    add_adl      = 1'b0;
    add_sb_60    = 1'b0;
    add_sb_7     = 1'b0;
    done         = done_now;
    index_sel    = index_sel_q;
    page_cross   = page_cross_q;
    case (state_q)
      ST_ADD_LO:   alu_add = 1'b1;
      ST_DRIVE_LO: add_adl = 1'b1;
      ST_ADD_HI: begin
        alu_add      = 1'b1;
        alu_sel_hi   = 1'b1;
        alu_carry_in = c_q;
      end
      ST_DRIVE_HI: begin
        add_sb_60 = 1'b1;
        add_sb_7  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_indexed_add_sequencer.sv
// Self-checking bench: three parameter variants driven in parallel against a
// cycle-indexed transaction model of the sequencing rules.
module tb_indexed_add_sequencer;

  logic       phi_2 = 1'b0;
  logic       reset, start, is_write, abort, alu_carry_out;
  logic [1:0] mode;

  logic [2:0] busy_w, index_sel_w, alu_add_w, alu_sel_hi_w, alu_carry_in_w;
  logic [2:0] add_adl_w, add_sb_60_w, add_sb_7_w, page_cross_w, done_w;

  int errors = 0;
  int checks = 0;

  localparam int unsigned D_OF[3] = '{1, 1, 3};
  localparam bit          F_OF[3] = '{1'b1, 1'b0, 1'b1};

  always #5 phi_2 = ~phi_2;

  indexed_add_sequencer #(.DRIVE_CYCLES(1), .FORCE_FIXUP_ON_WRITE(1'b1)) dut (
    .phi_2(phi_2), .reset(reset), .start(start), .mode(mode), .is_write(is_write),
    .abort(abort), .alu_carry_out(alu_carry_out), .busy(busy_w[0]),
    .index_sel(index_sel_w[0]), .alu_add(alu_add_w[0]), .alu_sel_hi(alu_sel_hi_w[0]),
    .alu_carry_in(alu_carry_in_w[0]), .add_adl(add_adl_w[0]), .add_sb_60(add_sb_60_w[0]),
    .add_sb_7(add_sb_7_w[0]), .page_cross(page_cross_w[0]), .done(done_w[0]));

  indexed_add_sequencer #(.DRIVE_CYCLES(1), .FORCE_FIXUP_ON_WRITE(1'b0)) dut_nf (
    .phi_2(phi_2), .reset(reset), .start(start), .mode(mode), .is_write(is_write),
    .abort(abort), .alu_carry_out(alu_carry_out), .busy(busy_w[1]),
    .index_sel(index_sel_w[1]), .alu_add(alu_add_w[1]), .alu_sel_hi(alu_sel_hi_w[1]),
    .alu_carry_in(alu_carry_in_w[1]), .add_adl(add_adl_w[1]), .add_sb_60(add_sb_60_w[1]),
    .add_sb_7(add_sb_7_w[1]), .page_cross(page_cross_w[1]), .done(done_w[1]));

  indexed_add_sequencer #(.DRIVE_CYCLES(3), .FORCE_FIXUP_ON_WRITE(1'b1)) dut_d3 (
    .phi_2(phi_2), .reset(reset), .start(start), .mode(mode), .is_write(is_write),
    .abort(abort), .alu_carry_out(alu_carry_out), .busy(busy_w[2]),
    .index_sel(index_sel_w[2]), .alu_add(alu_add_w[2]), .alu_sel_hi(alu_sel_hi_w[2]),
    .alu_carry_in(alu_carry_in_w[2]), .add_adl(add_adl_w[2]), .add_sb_60(add_sb_60_w[2]),
    .add_sb_7(add_sb_7_w[2]), .page_cross(page_cross_w[2]), .done(done_w[2]));

  // Bit order: busy alu_add sel_hi cin adl sb60 sb7 done page_cross index_sel
  function automatic logic [9:0] obs(input int i);
    return {busy_w[i], alu_add_w[i], alu_sel_hi_w[i], alu_carry_in_w[i], add_adl_w[i],
            add_sb_60_w[i], add_sb_7_w[i], done_w[i], page_cross_w[i], index_sel_w[i]};
  endfunction

  // Expected outputs k cycles after the accepting start edge.
  function automatic logic [9:0] exp_vec(input logic [1:0] m, input logic wr, input logic cy,
                                         input int d, input bit f, input int k);
    logic [9:0] v;
    bit ab, fix;
    int len;
    ab  = (m == 2'd1) || (m == 2'd2);
    fix = ab && (cy || (wr && f));
    len = fix ? 2 + 2 * d : 1 + d;
    v = '0;
    if (k >= 1 && k <= len) begin
      v[9] = 1'b1;
      if (k == 1) v[8] = 1'b1;
      else if (k <= 1 + d) begin
        v[5] = 1'b1;
        v[2] = (k == 1 + d) && !fix;
      end else if (k == 2 + d) begin
        v[8] = 1'b1; v[7] = 1'b1; v[6] = cy;
      end else begin
        v[4] = 1'b1; v[3] = 1'b1;
        v[2] = (k == len);
      end
    end
    v[1] = (k >= 2) && ab && cy;
    v[0] = m[1];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge phi_2);
    #1;
  endtask

  task automatic reset_all();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_inst%0d", i), obs(i), '0);
  endtask

  // poke=1 issues a conflicting start in cycle 1, which must be ignored.
  task automatic run_txn(input string tag, input logic [1:0] m, input logic wr,
                         input logic cy, input bit poke);
    mode = m; is_write = wr; alu_carry_out = cy; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("%s_inst%0d_k%0d", tag, i, k), obs(i),
            exp_vec(m, wr, cy, D_OF[i], F_OF[i], k));
      if (poke && k == 1) begin
        start = 1'b1; mode = ~m; is_write = ~wr;
      end
      step();
      start = 1'b0;
    end
  endtask

  logic [2:0] done_prev = '0;
  always @(negedge phi_2) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        assert (!(add_adl_w[i] && (add_sb_60_w[i] || add_sb_7_w[i])) &&
                (add_sb_60_w[i] === add_sb_7_w[i]) &&
                !(done_w[i] && done_prev[i])) else begin
          errors++;
          $error("FAIL invariant_inst%0d observed=adl%b sb60%b sb7%b done%b prev%b expected=exclusive",
                 i, add_adl_w[i], add_sb_60_w[i], add_sb_7_w[i], done_w[i], done_prev[i]);
        end
      end
    end
    done_prev <= reset ? 3'b000 : done_w;
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; is_write = 1'b0;
    mode = 2'b00; alu_carry_out = 1'b0;
    reset_all();

    // Reset mid-DRIVE_HI, then a clean abs,X short sequence.
    mode = 2'b10; is_write = 1'b0; alu_carry_out = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    chk("pre_reset_drive_hi", obs(0), exp_vec(2'b10, 1'b0, 1'b1, 1, 1'b1, 4));
    reset_all();
    run_txn("absx_rd_nc_after_reset", 2'b01, 1'b0, 1'b0, 1'b0);

    run_txn("absy_rd_carry", 2'b10, 1'b0, 1'b1, 1'b0);
    run_txn("absx_wr_nc", 2'b01, 1'b1, 1'b0, 1'b0);
    run_txn("zpx_wrap", 2'b00, 1'b0, 1'b1, 1'b0);
    run_txn("zpy_wr_carry", 2'b11, 1'b1, 1'b1, 1'b0);
    run_txn("start_in_add_lo", 2'b01, 1'b0, 1'b0, 1'b1);

    // Abort in ADD_HI: IDLE next, no done, page_cross kept.
    mode = 2'b01; is_write = 1'b0; alu_carry_out = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk("abort_pre_add_hi", obs(0), exp_vec(2'b01, 1'b0, 1'b1, 1, 1'b1, 3));
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_next", obs(0), 10'b0000000010);
    step();
    chk("abort_idle", obs(0), 10'b0000000010);
    reset_all();

    // Start in the done cycle chains without an IDLE bubble.
    mode = 2'b10; is_write = 1'b0; alu_carry_out = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    chk("chain_done_cycle", obs(0), exp_vec(2'b10, 1'b0, 1'b1, 1, 1'b1, 4));
    mode = 2'b00; start = 1'b1;
    step(); start = 1'b0;
    chk("chain_add_lo", obs(0), 10'b1100000000);
    chk("chain_add_lo_nf", obs(1), 10'b1100000000);
    step();
    chk("chain_done", obs(0), 10'b1000100100);
    step();
    chk("chain_idle", obs(0), 10'b0000000000);
    reset_all();

    for (int n = 0; n < 25; n++) begin
      run_txn($sformatf("rand%0d", n), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
